// File: rtl/cfu_requant_stage.sv
// TFLite-style int32 -> int8 requantizer behind the CFU cmd/rsp handshake.
// Pipeline: bias add + left shift, SRDHM multiply, rounding right shift + offset, clamp.
module cfu_requant_stage #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_payload_function_id,
  input  logic [ACC_W-1:0] cmd_payload_inputs_0,
  input  logic [ACC_W-1:0] cmd_payload_inputs_1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ACC_W-1:0] rsp_payload_outputs_0
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_SRD   = 3'd2,
    ST_SHR   = 3'd3,
    ST_CLAMP = 3'd4
  } state_e;

  localparam logic [ACC_W-1:0] BIAS_RST    = 32'h0000_0000;
  localparam logic [ACC_W-1:0] MULT_RST    = 32'h4000_0000;
  localparam logic [ACC_W-1:0] SHIFT_RST   = 32'h0000_0000;
  localparam logic [ACC_W-1:0] OFF_RST     = 32'h0000_0000;
  localparam logic [ACC_W-1:0] ACT_MIN_RST = 32'hFFFF_FF80;
  localparam logic [ACC_W-1:0] ACT_MAX_RST = 32'h0000_007F;

  localparam logic [6:0] F_RESET    = 7'd0;
  localparam logic [6:0] F_BIAS     = 7'd1;
  localparam logic [6:0] F_MULT     = 7'd2;
  localparam logic [6:0] F_OFF      = 7'd3;
  localparam logic [6:0] F_ACT      = 7'd4;
  localparam logic [6:0] F_REQUANT  = 7'd5;

  // Left shift amount: positive part of shift, capped at 31.
  function automatic logic [4:0] left_amt(input logic signed [31:0] s);
    if (s < 32'sd0) begin
      left_amt = 5'd0;
    end else if (s > 32'sd31) begin
      left_amt = 5'd31;
    end else begin
      left_amt = s[4:0];
    end
  endfunction

  // Right shift amount: negative part of shift, capped at 31 without negating -2^31.
  function automatic logic [4:0] right_amt(input logic signed [31:0] s);
    logic signed [31:0] neg;
    neg = 32'sd0 - s;
    if (s >= 32'sd0) begin
      right_amt = 5'd0;
    end else if (s < -32'sd31) begin
      right_amt = 5'd31;
    end else begin
      right_amt = neg[4:0];
    end
  endfunction

  state_e state_q, state_d;

  logic [ACC_W-1:0] bias_q, bias_d;
  logic [ACC_W-1:0] mult_q, mult_d;
  logic [ACC_W-1:0] shift_q, shift_d;
  logic [ACC_W-1:0] out_off_q, out_off_d;
  logic [ACC_W-1:0] act_min_q, act_min_d;
  logic [ACC_W-1:0] act_max_q, act_max_d;

  logic [ACC_W-1:0]        x_q, x_d;
  logic signed [63:0]      p_q, p_d;
  logic                    sat_q, sat_d;
  logic [ACC_W-1:0]        h_q, h_d;
  logic [ACC_W-1:0]        v_q, v_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ACC_W-1:0]        rsp_data_q, rsp_data_d;

  logic             cmd_ready_s;
  logic             accept_s;
  logic [6:0]       func7_s;

  logic signed [63:0] prod_s;
  logic               sat_s;
  logic signed [63:0] nudge_s;
  logic signed [63:0] sum_s;
  logic signed [63:0] adj_s;
  logic [ACC_W-1:0]   h_next_s;
  logic [4:0]         rs_s;
  logic [ACC_W-1:0]   mask_s;
  logic [ACC_W-1:0]   rem_s;
  logic [ACC_W-1:0]   thr_s;
  logic [ACC_W-1:0]   shifted_s;
  logic [ACC_W-1:0]   rounded_s;
  logic [ACC_W-1:0]   lo_s;
  logic [ACC_W-1:0]   clamp_s;
  logic               unused_s;

  assign func7_s  = cmd_payload_function_id[9:3];
  assign accept_s = cmd_valid && cmd_ready_s;

  assign prod_s = $signed({{32{x_q[31]}}, x_q}) * $signed({{32{mult_q[31]}}, mult_q});
  assign sat_s  = (x_q == 32'h8000_0000) && (mult_q == 32'h8000_0000);

  // Round half away from zero, then divide by 2^31 truncating toward zero.
  assign nudge_s  = p_q[63] ? -64'sd1073741823 : 64'sd1073741824;
  assign sum_s    = p_q + nudge_s;
  assign adj_s    = sum_s[63] ? (sum_s + 64'sd2147483647) : sum_s;
  assign h_next_s = sat_q ? 32'h7FFF_FFFF : adj_s[62:31];

  assign rs_s      = right_amt(shift_q);
  assign mask_s    = (32'd1 << rs_s) - 32'd1;
  assign rem_s     = h_q & mask_s;
  assign thr_s     = (mask_s >> 1) + {31'd0, h_q[31]};
  assign shifted_s = $signed(h_q) >>> rs_s;
  assign rounded_s = shifted_s + ((rem_s > thr_s) ? 32'd1 : 32'd0);

  // act_max is applied last so it wins when the bounds are inverted.
  assign lo_s    = ($signed(v_q) < $signed(act_min_q)) ? act_min_q : v_q;
  assign clamp_s = ($signed(lo_s) > $signed(act_max_q)) ? act_max_q : lo_s;

  assign unused_s = ^{cmd_payload_function_id[2:0], adj_s[63], adj_s[30:0]};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (func7_s == F_REQUANT)) begin
          state_d = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL:   state_d = ST_SRD;
      ST_SRD:   state_d = ST_SHR;
      ST_SHR:   state_d = ST_CLAMP;
      ST_CLAMP: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_ready_s = 1'b0;
    if ((state_q == ST_IDLE) && !rsp_valid_q) begin
      cmd_ready_s = 1'b1;
    end else begin
      cmd_ready_s = 1'b0;
    end
  end

  // Config, datapath and response next-state.
  always_comb begin
    bias_d      = bias_q;
    mult_d      = mult_q;
    shift_d     = shift_q;
    out_off_d   = out_off_q;
    act_min_d   = act_min_q;
    act_max_d   = act_max_q;
    x_d         = x_q;
    p_d         = p_q;
    sat_d       = sat_q;
    h_d         = h_q;
    v_d         = v_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (func7_s)
            F_RESET: begin
              bias_d    = BIAS_RST;
              mult_d    = MULT_RST;
              shift_d   = SHIFT_RST;
              out_off_d = OFF_RST;
              act_min_d = ACT_MIN_RST;
              act_max_d = ACT_MAX_RST;
            end
            F_BIAS: bias_d = cmd_payload_inputs_0;
            F_MULT: begin
              mult_d  = cmd_payload_inputs_0;
              shift_d = cmd_payload_inputs_1;
            end
            F_OFF: out_off_d = cmd_payload_inputs_0;
            F_ACT: begin
              act_min_d = cmd_payload_inputs_0;
              act_max_d = cmd_payload_inputs_1;
            end
            F_REQUANT: x_d = (cmd_payload_inputs_0 + bias_q) << left_amt(shift_q);
            default: x_d = x_q;
          endcase
          if (func7_s != F_REQUANT) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
          end else begin
            rsp_valid_d = rsp_valid_q;
          end
        end else if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      ST_MUL: begin
        p_d   = prod_s;
        sat_d = sat_s;
      end
      ST_SRD: h_d = h_next_s;
      ST_SHR: v_d = rounded_s + out_off_q;
      ST_CLAMP: begin
        rsp_data_d  = clamp_s;
        rsp_valid_d = 1'b1;
      end
      default: rsp_valid_d = rsp_valid_q;
    endcase
  end

  // Config, datapath and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q      <= BIAS_RST;
      mult_q      <= MULT_RST;
      shift_q     <= SHIFT_RST;
      out_off_q   <= OFF_RST;
      act_min_q   <= ACT_MIN_RST;
      act_max_q   <= ACT_MAX_RST;
      x_q         <= 32'd0;
      p_q         <= 64'sd0;
      sat_q       <= 1'b0;
      h_q         <= 32'd0;
      v_q         <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      bias_q      <= bias_d;
      mult_q      <= mult_d;
      shift_q     <= shift_d;
      out_off_q   <= out_off_d;
      act_min_q   <= act_min_d;
      act_max_q   <= act_max_d;
      x_q         <= x_d;
      p_q         <= p_d;
      sat_q       <= sat_d;
      h_q         <= h_d;
      v_q         <= v_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready             = cmd_ready_s;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

endmodule
